// File: rtl/i2s_tx.sv
// Philips I2S stereo transmitter for a mono sample stream.
// One-entry holding register; each sample fills both slots of a frame.
module i2s_tx #(
  parameter int width_p     = 24,
  parameter int slot_bits_p = 32,
  parameter int sclk_div_p  = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] sample_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               sclk_o,
  output logic               lrclk_o,
  output logic               sdata_o,
  output logic               underflow_o
);

  localparam int cnt_w_lp = $clog2(2 * slot_bits_p);
  localparam int div_w_lp = (sclk_div_p > 1) ? $clog2(sclk_div_p) : 1;

  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(2 * slot_bits_p - 1);
  localparam logic [cnt_w_lp-1:0] slot_lp     = cnt_w_lp'(slot_bits_p);
  localparam logic [cnt_w_lp-1:0] width_lp    = cnt_w_lp'(width_p);
  localparam logic [div_w_lp-1:0] div_last_lp = div_w_lp'(sclk_div_p - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e               state_q, state_d;
  logic [div_w_lp-1:0]  div_q, div_d;
  logic                 sclk_q, sclk_d;
  logic [cnt_w_lp-1:0]  bit_cnt_q, bit_cnt_d;
  logic                 lrclk_q, lrclk_d;
  logic                 sdata_q, sdata_d;
  logic [width_p-1:0]   shift_q, shift_d;
  logic [width_p-1:0]   hold_q, hold_d;
  logic                 full_q, full_d;
  logic                 ready_q, ready_d;
  logic                 underflow_q, underflow_d;

  logic                 tick;
  logic                 fall;
  logic [cnt_w_lp-1:0]  pos;
  logic [cnt_w_lp-1:0]  idx;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    bit_cnt_d   = bit_cnt_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    full_d      = full_q;
    underflow_d = 1'b0;
    pos         = '0;
    idx         = '0;

    tick = (div_q == div_last_lp);
    fall = tick && sclk_q;

    div_d = tick ? '0 : div_q + div_w_lp'(1);
    if (tick) begin
      sclk_d = !sclk_q;
    end

    unique case (state_q)
      IDLE: if (fall) state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == cnt_last_lp) ? '0 : bit_cnt_q + cnt_w_lp'(1);

      // Frame boundary: the right slot replays this word, no reload at mid-frame.
      if (bit_cnt_d == '0) begin
        if (full_q) begin
          shift_d = hold_q;
          full_d  = 1'b0;
        end else begin
          shift_d     = '0;
          underflow_d = 1'b1;
        end
      end

      lrclk_d = (bit_cnt_d >= slot_lp);
      pos     = lrclk_d ? bit_cnt_d - slot_lp : bit_cnt_d;
      idx     = width_lp - pos;
      sdata_d = 1'b0;
      if (pos >= cnt_w_lp'(1) && pos <= width_lp) begin
        sdata_d = |(shift_d & (width_p'(1) << idx));
      end
    end

    if (valid_i && ready_q) begin
      hold_d = sample_i;
      full_d = 1'b1;
    end

    ready_d = !full_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      div_q       <= '0;
      sclk_q      <= 1'b0;
      bit_cnt_q   <= cnt_last_lp;
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      ready_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      sclk_q      <= sclk_d;
      bit_cnt_q   <= bit_cnt_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      ready_q     <= ready_d;
      underflow_q <= underflow_d;
    end
  end

  assign ready_o     = ready_q;
  assign sclk_o      = sclk_q;
  assign lrclk_o     = lrclk_q;
  assign sdata_o     = sdata_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: time-based output model plus frame-level deserialiser.
module tb_i2s_tx;

  localparam int W   = 24;
  localparam int S   = 32;
  localparam int DIV = 4;
  localparam int FR  = 2 * S * 2 * DIV;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] sample_i;
  logic         valid_i;
  logic         ready_o, sclk_o, lrclk_o, sdata_o, underflow_o;

  i2s_tx #(.width_p(W), .slot_bits_p(S), .sclk_div_p(DIV)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .sample_i   (sample_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sclk_o     (sclk_o),
    .lrclk_o    (lrclk_o),
    .sdata_o    (sdata_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sample;
    logic [W-1:0] exp_left;
    logic [W-1:0] exp_right;
    bit           exp_uf;
  } vec_t;

  typedef struct {
    logic [W-1:0] left;
    logic [W-1:0] right;
    bit           uf;
  } frame_t;

  int           nchk = 0;
  int           nbad = 0;
  int           n;
  bit           m_full, m_ready, m_uf;
  logic [W-1:0] m_hold;
  logic [W-1:0] fw [64];
  bit           offer;
  logic [W-1:0] offer_data;
  logic [W-1:0] stream_q [$];
  frame_t       exp_q [$];
  logic [W-1:0] cap_l, cap_r;
  bit           cap_uf, cap_on;
  int           first_rise, first_fall, ready_hi;
  bit           prev_sclk;

  function automatic int ld(int f);
    return 2 * DIV + f * FR;
  endfunction

  task automatic chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h (n=%0d)", name, got, exp, n);
    end
  endtask

  task automatic check_cycle();
    int k, b, p, f;
    logic [4:0] e;
    logic lr, sd;
    k  = n / (2 * DIV);
    lr = 1'b1;
    sd = 1'b0;
    if (k > 0) begin
      b  = (k - 1) % (2 * S);
      f  = (k - 1) / (2 * S);
      p  = b % S;
      lr = (b >= S);
      if (p >= 1 && p <= W) sd = fw[f][W-p];
    end
    e = {1'((n / DIV) % 2), lr, sd, m_ready, m_uf};
    nchk++;
    if ({sclk_o, lrclk_o, sdata_o, ready_o, underflow_o} !== e) begin
      nbad++;
      $display("FAIL cycle n=%0d got=%b exp=%b", n,
               {sclk_o, lrclk_o, sdata_o, ready_o, underflow_o}, e);
    end
    if (ready_o === 1'b1) ready_hi++;
    if (sclk_o && !prev_sclk && first_rise < 0) first_rise = n;
    if (!sclk_o && prev_sclk && first_fall < 0) first_fall = n;
    prev_sclk = sclk_o;
  endtask

  task automatic capture();
    int k, b, p;
    frame_t e;
    if (n == 0 || n % (2 * DIV) != 0) return;
    k = n / (2 * DIV);
    b = (k - 1) % (2 * S);
    p = b % S;
    if (b == 0) begin
      cap_l  = '0;
      cap_r  = '0;
      cap_uf = underflow_o;
      cap_on = 1'b1;
    end
    if (p >= 1 && p <= W) begin
      if (b < S) cap_l = {cap_l[W-2:0], sdata_o};
      else       cap_r = {cap_r[W-2:0], sdata_o};
    end
    if (b == 2 * S - 1 && cap_on) begin
      if (exp_q.size() == 0) begin
        nchk++;
        nbad++;
        $display("FAIL frame_queue got=empty exp=entry (n=%0d)", n);
      end else begin
        e = exp_q.pop_front();
        chk("frame_left", cap_l, e.left);
        chk("frame_right", cap_r, e.right);
        chk("frame_uf", W'(cap_uf), W'(e.uf));
      end
    end
  endtask

  task automatic step();
    bit acc, load;
    if (!offer && stream_q.size() > 0) begin
      offer      = 1'b1;
      offer_data = stream_q.pop_front();
    end
    valid_i  = offer;
    sample_i = offer ? offer_data : W'($urandom);
    acc      = offer && m_ready;
    @(posedge clk);
    n++;
    load = (n >= 2 * DIV) && ((n - 2 * DIV) % FR == 0);
    m_uf = 1'b0;
    if (load) begin
      if (m_full) begin
        fw[(n - 2 * DIV) / FR] = m_hold;
        m_full = 1'b0;
      end else begin
        fw[(n - 2 * DIV) / FR] = '0;
        m_uf = 1'b1;
      end
    end
    if (acc) begin
      m_hold = sample_i;
      m_full = 1'b1;
      offer  = 1'b0;
    end
    m_ready = !m_full;
    @(negedge clk);
    check_cycle();
    capture();
  endtask

  task automatic run_to(int target);
    while (n < target) step();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    offer   = 1'b0;
    stream_q.delete();
    exp_q.delete();
    cap_on  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", W'({sclk_o, lrclk_o, sdata_o, ready_o, underflow_o}),
        W'(5'b01000));
    reset_i    = 1'b0;
    n          = 0;
    m_full     = 1'b0;
    m_ready    = 1'b0;
    m_uf       = 1'b0;
    first_rise = -1;
    first_fall = -1;
    prev_sclk  = 1'b0;
  endtask

  vec_t tbl [6];

  initial begin
    logic [W-1:0] r;
    tbl[0] = '{24'h000001, 24'h000001, 24'h000001, 1'b0};
    tbl[1] = '{24'h800000, 24'h800000, 24'h800000, 1'b0};
    tbl[2] = '{24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0};
    for (int i = 3; i < 6; i++) begin
      r = W'($urandom);
      tbl[i] = '{r, r, r, 1'b0};
    end

    sample_i = '0;
    do_reset();
    step();
    chk("ready_after_reset", W'(ready_o), W'(1));

    offer      = 1'b1;
    offer_data = 24'hABCDEF;
    exp_q.push_back('{24'hABCDEF, 24'hABCDEF, 1'b0});
    run_to(ld(0));
    chk("sclk_first_rise", W'(first_rise), W'(4));
    chk("sclk_first_fall", W'(first_fall), W'(8));

    exp_q.push_back('{'0, '0, 1'b1});
    run_to(ld(1));

    r = W'($urandom);
    run_to(ld(2) - 1);
    offer      = 1'b1;
    offer_data = r;
    exp_q.push_back('{'0, '0, 1'b1});
    exp_q.push_back('{r, r, 1'b0});
    step();
    chk("late_accept_uf", W'(underflow_o), W'(1));
    run_to(ld(3));

    for (int i = 0; i < 6; i++) begin
      stream_q.push_back(tbl[i].sample);
      exp_q.push_back('{tbl[i].exp_left, tbl[i].exp_right, tbl[i].exp_uf});
    end
    run_to(ld(5));
    ready_hi = 0;
    run_to(ld(6));
    chk("stream_ready_high_cycles", W'(ready_hi), W'(1));
    run_to(ld(9));

    for (int f = 9; f < 15; f++) begin
      if ($urandom_range(0, 2) != 0) begin
        r = W'($urandom);
        exp_q.push_back('{r, r, 1'b0});
        run_to(ld(f) + int'($urandom_range(1, 400)));
        offer      = 1'b1;
        offer_data = r;
      end else begin
        exp_q.push_back('{'0, '0, 1'b1});
      end
      run_to(ld(f + 1));
    end

    offer      = 1'b1;
    offer_data = 24'h5A5A5A;
    run_to(ld(15) + 320);
    chk("midframe_lrclk", W'(lrclk_o), W'(1));
    do_reset();

    exp_q.push_back('{'0, '0, 1'b1});
    exp_q.push_back('{'0, '0, 1'b1});
    run_to(ld(1));
    chk("frames_pending", W'(exp_q.size()), W'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Downstream stage of the volume block: consumes its 24-bit attenuated `sound_o` stream and serialises it as a Philips I2S stereo frame toward the codec DAC.
- Mono source: each accepted sample is transmitted on both left and right slots of one frame.
- A one-entry holding register with valid/ready decouples the sample producer from the frame timing.

Parameters:
- `width_p`, 24: sample width in bits; must be ≤ `slot_bits_p` − 1.
- `slot_bits_p`, 32: sclk periods per channel slot. A frame is 2×`slot_bits_p` sclk periods.
- `sclk_div_p`, 4: clk_i cycles per sclk half-period; must be ≥ 1. One sclk period is 2×`sclk_div_p` clk_i cycles.

Ports:
- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `reset_i`  in  1  synchronous reset, active-high.
- `sample_i`  in  `width_p`  two's-complement sample, typically the volume block's `sound_o`.
- `valid_i`  in  1  `sample_i` is valid this cycle.
- `ready_o`  out  1  holding register is empty; a transfer occurs when `valid_i` && `ready_o`.
- `sclk_o`  out  1  I2S bit clock.
- `lrclk_o`  out  1  word select: 0 = left slot, 1 = right slot.
- `sdata_o`  out  1  serial data, MSB first.
- `underflow_o`  out  1  one-cycle pulse when a frame starts with the holding register empty.

Behaviour:
- Reset values (registered, take effect the cycle after `reset_i` is sampled high):
  - `div_r` = 0, `sclk_o` = 0, `bit_cnt_r` = 2×`slot_bits_p` − 1, `lrclk_o` = 1, `sdata_o` = 0.
  - `shift_r` = 0, holding register empty, `ready_o` = 0 while `reset_i` is high, `underflow_o` = 0.
  - Reset asserted mid-frame aborts the frame immediately; the holding contents are discarded.
- Divider:
  - `div_r` counts 0..`sclk_div_p`−1 and wraps.
  - On the wrap cycle ("tick"), `sclk_o` toggles.
  - A tick where `sclk_o` goes 1→0 is a "fall tick".
  - The first fall tick after reset occurs 2×`sclk_div_p` cycles after reset deassertion.
- Bit counter:
  - On each fall tick, `bit_cnt_r` increments modulo 2×`slot_bits_p`. 63 wraps to 0 at defaults.
  - All outputs change only on fall ticks; the codec samples on sclk rising edges.
- Slot position:
  - `p` = `bit_cnt_r` mod `slot_bits_p`.
  - `lrclk_o` = 0 for `bit_cnt_r` < `slot_bits_p`, 1 otherwise. It changes one sclk before the MSB, per the I2S one-bit delay.
- Serial data per slot:
  - `p` = 0: delay bit, `sdata_o` = 0.
  - `p` = 1..`width_p`: `sample[width_p − p]` (MSB first).
  - `p` > `width_p`: 0.
- Frame load, on the fall tick where `bit_cnt_r` wraps to 0:
  - If the holding register is full: `shift_r` ← holding, holding becomes empty, `ready_o` rises the next cycle.
  - If the holding register is empty: `shift_r` ← 0 and `underflow_o` = 1 for exactly that cycle.
  - The right slot replays `shift_r`; there is no reload at `bit_cnt_r` = `slot_bits_p`.
- Handshake:
  - `ready_o` = !full, registered.
  - An accept in the same cycle as a frame load while empty does not bypass: that frame underflows and the sample is sent in the next frame.
  - When full, `valid_i` is ignored and `sample_i` need not be held stable by the producer beyond the accept cycle.
- Steady-state throughput: one sample per frame, i.e. 2×`slot_bits_p`×2×`sclk_div_p` clk_i cycles. This is 512 cycles at defaults.
- Implementation: FSM `IDLE` (post-reset, before first fall tick) → `RUN`; no other states.

Test Plan:
- Reset → after reset: `sclk_o` = 0, `lrclk_o` = 1, `sdata_o` = 0, `ready_o` = 1 the cycle after `reset_i` falls.
  - First `sclk_o` rise 4 cycles and first fall 8 cycles after deassertion (`sclk_div_p` = 4).
- Present `sample_i` = 24'hABCDEF, `valid_i` = 1 before the first fall tick → `ready_o` = 0 the next cycle, rises at frame load.
  - Left slot bits `p` = 1..24 are 1010_1011_1100_1101_1110_1111, `p` = 0 and `p` = 25..31 are 0.
  - Right slot is identical; `lrclk_o` toggles at `bit_cnt_r` = 0 and 32.
- No `valid_i` at the frame boundary → `underflow_o` is a single-cycle pulse; the frame is all zeros on both slots.
- `valid_i` raised in exactly the frame-load cycle with the holding register empty → underflow pulse, sample transmitted in the following frame.
- Stream 24'h000001, 24'h800000, 24'h7FFFFF with `valid_i` held high → one accept per frame, no underflow.
  - Frames carry the three values in order; `ready_o` is low for 511 of every 512 cycles.
- Assert `reset_i` at `bit_cnt_r` = 40 of a frame with a full holding register → next cycle all outputs at reset values.
  - The held sample is never transmitted.
